// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for a 5-stage ARM-like pipeline.
// A small shadow copy of the EX/MEM/WB destination info is kept locally so
// forwarding selects and load-use stalls can be decided combinationally in ID.
module hazard_fwd_unit (
  input  logic        clk,
  input  logic        reset,
  // decoded control from the control unit
  input  logic        dec_reg_write_enable,
  input  logic        dec_mem_enable,
  input  logic        dec_mem_rw,
  input  logic        dec_mem_to_reg_select,
  input  logic        dec_alu_src_select,
  input  logic [3:0]  dec_alu_control,
  input  logic        dec_status_bit,
  input  logic        dec_mem_size,
  input  logic [1:0]  dec_am_bits,
  input  logic        dec_pc_src_select,
  // gated control toward the ID/EX register
  output logic        ctl_reg_write_enable,
  output logic        ctl_mem_enable,
  output logic        ctl_mem_rw,
  output logic        ctl_mem_to_reg_select,
  output logic        ctl_alu_src_select,
  output logic [3:0]  ctl_alu_control,
  output logic        ctl_status_bit,
  output logic        ctl_mem_size,
  output logic [1:0]  ctl_am_bits,
  output logic        ctl_pc_src_select,
  // ID-stage instruction information
  input  logic        id_valid,
  input  logic        id_cond_pass,
  input  logic [3:0]  id_rn,
  input  logic [3:0]  id_rm,
  input  logic [3:0]  id_rd,
  input  logic        id_uses_rn,
  input  logic        id_uses_rm,
  input  logic        id_uses_rd,
  input  logic        branch_taken,
  // pipeline control
  output logic        pc_le,
  output logic        ifid_le,
  output logic        ifid_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  fwd_c,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  localparam logic [3:0] PC_REG = 4'd15;
  localparam int         NSTG   = 3;   // 0 = EX, 1 = MEM, 2 = WB

  typedef struct packed {
    logic       valid;
    logic [3:0] rd;
    logic       wr;
    logic       load;
  } shadow_t;

  shadow_t shadow_q [NSTG];
  shadow_t shadow_d [NSTG];

  // An entry supplies register r only if it really writes it; R15 is never forwarded.
  function automatic logic ent_match(input shadow_t e, input logic [3:0] r);
    return e.valid & e.wr & (e.rd == r) & (r != PC_REG);
  endfunction

  // Youngest producer wins: EX, then MEM, then WB, else the register file.
  function automatic logic [1:0] pick_src(input shadow_t ex, input shadow_t mem,
                                          input shadow_t wb, input logic [3:0] r,
                                          input logic uses);
    if (!uses)                   return 2'b00;
    else if (ent_match(ex, r))   return 2'b01;
    else if (ent_match(mem, r))  return 2'b10;
    else if (ent_match(wb, r))   return 2'b11;
    else                         return 2'b00;
  endfunction

  logic [2:0][3:0] src_reg;
  logic [2:0]      src_use;
  logic [2:0]      ex_hit;
  logic [2:0][1:0] src_sel;
  logic            stall;
  logic            issue;
  logic            pass;
  logic            load_id;
  logic [13:0]     dec_bus;
  logic [13:0]     ctl_bus;

  assign src_reg = {id_rd, id_rm, id_rn};
  assign src_use = {id_uses_rd, id_uses_rm, id_uses_rn};

  // Per-source forwarding select and EX-stage hit detection (rn, rm, rd).
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_src
      assign ex_hit[gi]  = src_use[gi] & ent_match(shadow_q[0], src_reg[gi]);
      assign src_sel[gi] = reset ? 2'b00
                                 : pick_src(shadow_q[0], shadow_q[1], shadow_q[2],
                                            src_reg[gi], src_use[gi]);
    end
  endgenerate

  assign fwd_a = src_sel[0];
  assign fwd_b = src_sel[1];
  assign fwd_c = src_sel[2];

  // A load still in EX cannot forward its data yet, so the consumer waits a cycle.
  assign stall   = ~reset & id_valid & shadow_q[0].load & (|ex_hit);
  assign issue   = id_valid & ~stall;
  assign pass    = ~reset & id_valid & id_cond_pass & ~stall;

  assign pc_le      = ~stall;
  assign ifid_le    = ~stall;
  assign ifid_flush = ~reset & branch_taken & ~stall;

  assign dec_bus = {dec_reg_write_enable, dec_mem_enable, dec_mem_rw,
                    dec_mem_to_reg_select, dec_alu_src_select, dec_alu_control,
                    dec_status_bit, dec_mem_size, dec_am_bits, dec_pc_src_select};
  assign ctl_bus = dec_bus & {14{pass}};
  assign {ctl_reg_write_enable, ctl_mem_enable, ctl_mem_rw,
          ctl_mem_to_reg_select, ctl_alu_src_select, ctl_alu_control,
          ctl_status_bit, ctl_mem_size, ctl_am_bits, ctl_pc_src_select} = ctl_bus;

  // Only a memory read that writes back from memory counts as a load.
  assign load_id = ctl_mem_enable & ~ctl_mem_rw & ctl_mem_to_reg_select;

  // Next shadow contents: new ID entry enters EX, older entries shift toward WB.
  always_comb begin
    shadow_d[0] = {issue, id_rd, ctl_reg_write_enable, load_id};
    for (int i = 1; i < NSTG; i++) shadow_d[i] = shadow_q[i-1];
    if (reset) begin
      for (int i = 0; i < NSTG; i++) shadow_d[i] = '0;
    end
  end

  // Shadow pipeline registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSTG; i++) shadow_q[i] <= shadow_d[i];
  end

  // Saturating performance counters: index 0 counts stalls, index 1 counts flushes.
  logic [1:0]       cnt_inc;
  logic [1:0][15:0] cnt_val;

  assign cnt_inc = {ifid_flush, stall};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [15:0] cnt_q;
      logic [15:0] cnt_d;

      // Hold at all-ones instead of wrapping.
      always_comb begin
        cnt_d = cnt_q;
        if (reset)
          cnt_d = '0;
        else if (cnt_inc[gi] && (cnt_q != 16'hFFFF))
          cnt_d = cnt_q + 16'd1;
      end

      // Counter register.
      always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
      end

      assign cnt_val[gi] = cnt_q;
    end
  endgenerate

  assign stall_count = cnt_val[0];
  assign flush_count = cnt_val[1];

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: a driver issues one ID-stage situation
// per cycle and queues the expected response from a history-based model; a
// monitor pops and compares on the falling edge.
module tb_hazard_fwd_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_reg_write_enable, dec_mem_enable, dec_mem_rw, dec_mem_to_reg_select;
  logic        dec_alu_src_select, dec_status_bit, dec_mem_size, dec_pc_src_select;
  logic [3:0]  dec_alu_control;
  logic [1:0]  dec_am_bits;
  logic        ctl_reg_write_enable, ctl_mem_enable, ctl_mem_rw, ctl_mem_to_reg_select;
  logic        ctl_alu_src_select, ctl_status_bit, ctl_mem_size, ctl_pc_src_select;
  logic [3:0]  ctl_alu_control;
  logic [1:0]  ctl_am_bits;
  logic        id_valid, id_cond_pass, branch_taken;
  logic [3:0]  id_rn, id_rm, id_rd;
  logic        id_uses_rn, id_uses_rm, id_uses_rd;
  logic        pc_le, ifid_le, ifid_flush;
  logic [1:0]  fwd_a, fwd_b, fwd_c;
  logic [15:0] stall_count, flush_count;

  always #5 clk = ~clk;

  hazard_fwd_unit dut (
    .clk(clk), .reset(reset),
    .dec_reg_write_enable(dec_reg_write_enable), .dec_mem_enable(dec_mem_enable),
    .dec_mem_rw(dec_mem_rw), .dec_mem_to_reg_select(dec_mem_to_reg_select),
    .dec_alu_src_select(dec_alu_src_select), .dec_alu_control(dec_alu_control),
    .dec_status_bit(dec_status_bit), .dec_mem_size(dec_mem_size),
    .dec_am_bits(dec_am_bits), .dec_pc_src_select(dec_pc_src_select),
    .ctl_reg_write_enable(ctl_reg_write_enable), .ctl_mem_enable(ctl_mem_enable),
    .ctl_mem_rw(ctl_mem_rw), .ctl_mem_to_reg_select(ctl_mem_to_reg_select),
    .ctl_alu_src_select(ctl_alu_src_select), .ctl_alu_control(ctl_alu_control),
    .ctl_status_bit(ctl_status_bit), .ctl_mem_size(ctl_mem_size),
    .ctl_am_bits(ctl_am_bits), .ctl_pc_src_select(ctl_pc_src_select),
    .id_valid(id_valid), .id_cond_pass(id_cond_pass),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_uses_rd(id_uses_rd),
    .branch_taken(branch_taken),
    .pc_le(pc_le), .ifid_le(ifid_le), .ifid_flush(ifid_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  logic [13:0] ctl_all;
  assign ctl_all = {ctl_reg_write_enable, ctl_mem_enable, ctl_mem_rw, ctl_mem_to_reg_select,
                    ctl_alu_src_select, ctl_alu_control, ctl_status_bit, ctl_mem_size,
                    ctl_am_bits, ctl_pc_src_select};

  // dec bit positions: 13 reg_write, 12 mem_en, 11 mem_rw, 10 mem_to_reg
  localparam bit [13:0] DEC_ALU = 14'b1_0_0_0_0_0100_0_0_00_0;
  localparam bit [13:0] DEC_LDR = 14'b1_1_0_1_1_0100_0_0_01_0;
  localparam bit [13:0] DEC_STR = 14'b0_1_1_0_1_0100_0_1_01_0;

  typedef struct {
    bit rst, valid, cond, br;
    bit [3:0] rn, rm, rd;
    bit urn, urm, urd;
    bit [13:0] dec;
  } stim_t;

  typedef struct {
    bit quiet, stall, pc_le, flush;
    bit [13:0] ctl;
    bit [1:0] fa, fb, fc;
    bit [15:0] scnt, fcnt;
  } exp_t;

  typedef struct { bit valid; bit [3:0] rd; bit wr; bit load; } issued_t;

  // Reference model: the last three issued instructions, newest first.
  issued_t hist[$];
  int      stall_n, flush_n;
  exp_t    sb[$];
  int      total = 0;
  int      bad   = 0;
  int      txn   = 0;

  function automatic bit [1:0] model_src(bit [3:0] r, bit used);
    if (!used || r == 4'd15) return 2'b00;
    for (int age = 0; age < hist.size(); age++)
      if (hist[age].valid && hist[age].wr && hist[age].rd == r) return 2'(age + 1);
    return 2'b00;
  endfunction

  task automatic drive_issue(input stim_t s, input bit quiet);
    exp_t e;
    bit [1:0] sa, sbb, sc;
    @(posedge clk);
    #1;
    reset = s.rst; id_valid = s.valid; id_cond_pass = s.cond; branch_taken = s.br;
    id_rn = s.rn; id_rm = s.rm; id_rd = s.rd;
    id_uses_rn = s.urn; id_uses_rm = s.urm; id_uses_rd = s.urd;
    {dec_reg_write_enable, dec_mem_enable, dec_mem_rw, dec_mem_to_reg_select,
     dec_alu_src_select, dec_alu_control, dec_status_bit, dec_mem_size,
     dec_am_bits, dec_pc_src_select} = s.dec;

    sa = model_src(s.rn, s.urn); sbb = model_src(s.rm, s.urm); sc = model_src(s.rd, s.urd);
    e.quiet = quiet;
    e.stall = !s.rst && s.valid && hist.size() > 0 && hist[0].load &&
              (sa == 2'd1 || sbb == 2'd1 || sc == 2'd1);
    e.pc_le = !e.stall;
    e.flush = !s.rst && s.br && !e.stall;
    e.ctl   = (!s.rst && s.valid && s.cond && !e.stall) ? s.dec : 14'd0;
    e.fa    = s.rst ? 2'b00 : sa;
    e.fb    = s.rst ? 2'b00 : sbb;
    e.fc    = s.rst ? 2'b00 : sc;
    e.scnt  = 16'(stall_n);
    e.fcnt  = 16'(flush_n);
    sb.push_back(e);

    // advance the model past the coming edge
    if (s.rst) begin
      hist.delete();
      stall_n = 0;
      flush_n = 0;
    end else begin
      if (e.stall && stall_n < 65535) stall_n++;
      if (e.flush && flush_n < 65535) flush_n++;
      hist.push_front('{s.valid && !e.stall, s.rd, e.ctl[13],
                        e.ctl[12] && !e.ctl[11] && e.ctl[10]});
      if (hist.size() > 3) void'(hist.pop_back());
    end
  endtask

  function automatic stim_t mk(bit valid, bit [13:0] dec, bit [3:0] rd, bit [3:0] rn,
                               bit [3:0] rm, bit urn, bit urm, bit urd);
    stim_t s;
    s.rst = 0; s.valid = valid; s.cond = 1; s.br = 0;
    s.rd = rd; s.rn = rn; s.rm = rm;
    s.urn = urn; s.urm = urm; s.urd = urd; s.dec = dec;
    return s;
  endfunction

  function automatic stim_t alu(bit [3:0] rd, bit [3:0] rn, bit [3:0] rm);
    return mk(1, DEC_ALU, rd, rn, rm, 1, 1, 0);
  endfunction
  function automatic stim_t ldr(bit [3:0] rd, bit [3:0] rn);
    return mk(1, DEC_LDR, rd, rn, 0, 1, 0, 0);
  endfunction
  function automatic stim_t str(bit [3:0] rd, bit [3:0] rn);
    return mk(1, DEC_STR, rd, rn, 0, 1, 0, 1);
  endfunction
  function automatic stim_t nop();
    return mk(0, 14'd0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL txn %0d %s: got %0h expected %0h", txn, name, act, expv);
    end
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        txn++;
        chk("ctl", 32'(ctl_all), 32'(e.ctl));
        chk("pc_le", 32'(pc_le), 32'(e.pc_le));
        chk("ifid_le", 32'(ifid_le), 32'(e.pc_le));
        chk("ifid_flush", 32'(ifid_flush), 32'(e.flush));
        if (!e.stall) begin
          chk("fwd_a", 32'(fwd_a), 32'(e.fa));
          chk("fwd_b", 32'(fwd_b), 32'(e.fb));
          chk("fwd_c", 32'(fwd_c), 32'(e.fc));
        end
        chk("stall_count", 32'(stall_count), 32'(e.scnt));
        chk("flush_count", 32'(flush_count), 32'(e.fcnt));
        if (!e.quiet)
          $display("txn %0d: ctl=%h pc_le=%b ifid_le=%b flush=%b fwd=%0d/%0d/%0d stall_cnt=%0d flush_cnt=%0d",
                   txn, ctl_all, pc_le, ifid_le, ifid_flush, fwd_a, fwd_b, fwd_c,
                   stall_count, flush_count);
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1; id_valid = 0; id_cond_pass = 0; branch_taken = 0;
    id_rn = 0; id_rm = 0; id_rd = 0; id_uses_rn = 0; id_uses_rm = 0; id_uses_rd = 0;
    {dec_reg_write_enable, dec_mem_enable, dec_mem_rw, dec_mem_to_reg_select,
     dec_alu_src_select, dec_alu_control, dec_status_bit, dec_mem_size,
     dec_am_bits, dec_pc_src_select} = 14'd0;
    repeat (3) @(posedge clk);
    hist.delete(); stall_n = 0; flush_n = 0;

    // reset state, with a would-be hazard present on the inputs
    s = alu(4'd1, 4'd2, 4'd3); s.rst = 1; s.br = 1; drive_issue(s, 0);

    // load-use: one stall, then MEM forwarding
    drive_issue(ldr(4'd2, 4'd1), 0);
    drive_issue(alu(4'd3, 4'd2, 4'd1), 0);
    drive_issue(alu(4'd3, 4'd2, 4'd1), 0);

    // EX beats MEM; then a bubble between gives MEM
    drive_issue(alu(4'd4, 4'd1, 4'd1), 0);
    drive_issue(alu(4'd4, 4'd1, 4'd1), 0);
    drive_issue(alu(4'd5, 4'd4, 4'd4), 0);
    drive_issue(alu(4'd4, 4'd1, 4'd1), 0);
    drive_issue(nop(), 0);
    drive_issue(alu(4'd5, 4'd4, 4'd4), 0);
    drive_issue(str(4'd5, 4'd4), 0);

    // WB forwarding and R15 never forwarded
    drive_issue(alu(4'd7, 4'd1, 4'd1), 0);
    drive_issue(alu(4'd15, 4'd1, 4'd1), 0);
    drive_issue(nop(), 0);
    drive_issue(alu(4'd8, 4'd7, 4'd15), 0);

    // failed condition: no control, no later forwarding of r9
    s = alu(4'd9, 4'd1, 4'd1); s.cond = 0; drive_issue(s, 0);
    drive_issue(alu(4'd10, 4'd9, 4'd9), 0);
    drive_issue(str(4'd9, 4'd9), 0);

    // stall and branch together, then branch alone
    drive_issue(ldr(4'd2, 4'd1), 0);
    s = alu(4'd3, 4'd1, 4'd2); s.br = 1; drive_issue(s, 0);
    drive_issue(s, 0);
    drive_issue(nop(), 0);

    // flush counter saturation
    s = nop(); s.br = 1;
    for (int i = 0; i < 65540; i++) drive_issue(s, 1);
    drive_issue(s, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      s.rst   = ($urandom_range(0, 99) < 2);
      s.valid = ($urandom_range(0, 9) != 0);
      s.cond  = ($urandom_range(0, 99) < 85);
      s.br    = ($urandom_range(0, 99) < 15);
      s.rn    = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      s.rm    = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      s.rd    = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      s.urn   = 1'($urandom_range(0, 1));
      s.urm   = 1'($urandom_range(0, 1));
      s.urd   = 1'($urandom_range(0, 1));
      s.dec   = 14'($urandom);
      if ($urandom_range(0, 9) < 4) begin
        s.dec[13] = 1; s.dec[12] = 1; s.dec[11] = 0; s.dec[10] = 1;
      end
      drive_issue(s, 0);
    end

    // reset in the middle of a load-use stall
    drive_issue(nop(), 0);
    drive_issue(ldr(4'd6, 4'd1), 0);
    drive_issue(alu(4'd1, 4'd6, 4'd6), 0);
    s = alu(4'd1, 4'd6, 4'd6); s.rst = 1; drive_issue(s, 0);
    drive_issue(alu(4'd1, 4'd6, 4'd6), 0);
    drive_issue(nop(), 0);

    // let the monitor drain, bounded
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
